// File: rtl/gf_share_expand_4_masked_pkg.sv
// Shared constants and expansion functions for the GF(2^4) share expander.
//
// Contents:
//   LFSR_W      width of the mask PRNG
//   LFSR_RST    PRNG reset value, also substituted for an all-zero seed
//   LFSR_TAPS   Galois feedback constant applied when the shifted-out bit is 1
//   SHARE_W     width of one expanded element {sum, hi, lo}
//   e2()        expands a GF(2^2) element {y1, y0} to {y1^y0, y1, y0}
//   expand()    expands a GF(2^4) element {hi, lo} to {E2(hi^lo), E2(hi), E2(lo)}
//
// The masked multiplier benches import this package so that their reference
// models share one definition of the expanded format.

package gf_share_expand_4_masked_pkg;

   localparam int unsigned LFSR_W  = 8;
   localparam int unsigned SHARE_W = 9;
   localparam int unsigned NIB_W   = 4;

   localparam logic [LFSR_W-1:0] LFSR_RST  = 8'h01;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

   typedef logic [SHARE_W-1:0] share_t;
   typedef logic [NIB_W-1:0]   nib_t;

   function automatic logic [2:0] e2(input logic [1:0] y);
      return {y[1] ^ y[0], y[1], y[0]};
   endfunction

   // Expansion is linear over XOR, so E(x^m) ^ E(m) == E(x); the masked pair
   // relies on that property.
   function automatic share_t expand(input nib_t x);
      logic [1:0] hi;
      logic [1:0] lo;
      hi = x[3:2];
      lo = x[1:0];
      return {e2(hi ^ lo), e2(hi), e2(lo)};
   endfunction

endpackage

// File: rtl/gf_share_expand_4_masked_lfsr.sv
// gf_share_lfsr_8 -- 8-bit Galois LFSR used as the mask source.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, value returns to LFSR_RST
//   load     load seed this cycle (wins over advance)
//   seed     seed value; 8'h00 is replaced by LFSR_RST
//   advance  step the sequence once
//   value    current PRNG state

module gf_share_lfsr_8
   import gf_share_expand_4_masked_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              advance,
   output logic [LFSR_W-1:0] value
);

   logic [LFSR_W-1:0] value_step;
   logic [LFSR_W-1:0] seed_safe;

   assign value_step = (value >> 1) ^ (value[0] ? LFSR_TAPS : '0);

   // All-zero is the lock-up state of the LFSR and must never be loaded.
   assign seed_safe = (seed == '0) ? LFSR_RST : seed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= LFSR_RST;
      end else if (load) begin
         value <= seed_safe;
      end else if (advance) begin
         value <= value_step;
      end
   end

endmodule

// File: rtl/gf_share_expand_4_masked.sv
// gf_share_expand_4_masked -- expands a GF(2^4) nibble into a masked pair of
// shared-factor words, one pair per accepted input, single-entry output buffer.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   seed_load/seed load the mask PRNG (zero seed becomes 8'h01)
//   in_valid/in_ready/in_data     input nibble handshake
//   out_valid/out_ready           output pair handshake
//   out_masked     E(in_data ^ m)
//   out_mask       E(m)
//   out_count      accepted transactions modulo 256
//
// Build option: GF_SHARE_MASK_EN selects masking with m = lfsr[3:0] sampled at
// acceptance. Without it m is zero, out_mask stays zero and out_masked is
// E(in_data); the PRNG still runs but does not reach the outputs.
//
// Output buffer states:
//   state    | meaning
//   ST_EMPTY | no pair held, out_valid = 0
//   ST_FULL  | pair held on the outputs, out_valid = 1

module gf_share_expand_4_masked
   import gf_share_expand_4_masked_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_load,
   input  logic [LFSR_W-1:0]  seed,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NIB_W-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SHARE_W-1:0] out_masked,
   output logic [SHARE_W-1:0] out_mask,
   output logic [7:0]         out_count
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   buf_state_t        state;
   buf_state_t        state_nxt;
   logic              accept;
   logic              xmit;
   logic [LFSR_W-1:0] lfsr_value;
   nib_t              mask_nib;
   logic              unused_lfsr;

   gf_share_lfsr_8 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (seed_load),
      .seed    (seed),
      .advance (accept),
      .value   (lfsr_value)
   );

   // The mask is taken from the register output, so a seed load in the same
   // cycle as an acceptance still masks with the pre-load value.
`ifdef GF_SHARE_MASK_EN
   assign mask_nib    = lfsr_value[3:0];
   assign unused_lfsr = ^lfsr_value[7:4];
`else
   assign mask_nib    = '0;
   assign unused_lfsr = ^lfsr_value;
`endif

   assign out_valid = (state == ST_FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign xmit      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            // A new pair arriving on the same edge as a transmission replaces
            // the old one without dropping out_valid.
            if (!accept && xmit) begin
               state_nxt = ST_EMPTY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_masked <= '0;
         out_mask   <= '0;
      end else if (accept) begin
         out_masked <= expand(in_data ^ mask_nib);
         out_mask   <= expand(mask_nib);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_count <= '0;
      end else if (accept) begin
         out_count <= out_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_gf_share_expand_4_masked.sv
module tb_gf_share_expand_4_masked;

`ifdef GF_SHARE_MASK_EN
   localparam bit MASK_ON = 1'b1;
`else
   localparam bit MASK_ON = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       seed_load;
   logic [7:0] seed;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] out_masked;
   logic [8:0] out_mask;
   logic [7:0] out_count;

   int total;
   int bad;

   // reference model state
   bit         m_valid;
   logic [3:0] m_data;
   logic [3:0] m_m;
   int         m_count;
   logic [7:0] m_lfsr;

   gf_share_expand_4_masked dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_load  (seed_load),
      .seed       (seed),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_masked (out_masked),
      .out_mask   (out_mask),
      .out_count  (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {parity, a1, a0} of a 2-bit value a is parity*4 + a
   function automatic logic [8:0] ref_expand(input int x);
      int hi, lo, r;
      int p[3];
      hi = (x / 4) % 4;
      lo = x % 4;
      p[0] = hi ^ lo;
      p[1] = hi;
      p[2] = lo;
      r = 0;
      for (int k = 0; k < 3; k++)
         r = r * 8 + ((p[k] / 2 + p[k]) % 2) * 4 + p[k];
      return 9'(r);
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return (s >> 1) ^ ((s % 2 == 1) ? 8'hB8 : 8'h00);
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_count = 0;
      m_lfsr  = 8'h01;
   endtask

   task automatic check_outputs();
      chk_eq("out_valid", 32'(out_valid), 32'(m_valid));
      chk_eq("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk_eq("out_count", 32'(out_count), 32'(m_count));
      chk_eq("lfsr", 32'(dut.lfsr_value), 32'(m_lfsr));
      if (m_valid) begin
         chk_eq("out_mask", 32'(out_mask), 32'(ref_expand(int'(m_m))));
         chk_eq("out_masked", 32'(out_masked), 32'(ref_expand(int'(m_data ^ m_m))));
         chk_eq("recombine", 32'(out_masked ^ out_mask), 32'(ref_expand(int'(m_data))));
      end
   endtask

   task automatic step();
      bit rdy, acc, tx;
      @(posedge clk);
      rdy = !m_valid || out_ready;
      acc = in_valid && rdy;
      tx  = m_valid && out_ready;
      if (acc) begin
         m_data  = in_data;
         m_m     = MASK_ON ? m_lfsr[3:0] : 4'h0;
         m_valid = 1'b1;
         m_count = (m_count + 1) % 256;
      end else if (tx) begin
         m_valid = 1'b0;
      end
      if (seed_load) m_lfsr = (seed == 8'h00) ? 8'h01 : seed;
      else if (acc)  m_lfsr = lfsr_next(m_lfsr);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [8:0] held_masked;
      logic [8:0] held_mask;
      logic [7:0] held_count;
      logic [3:0] stream [3];
      logic [8:0] stream_exp [3];

      total = 0;
      bad   = 0;
      rst_n     = 1'b0;
      seed_load = 1'b0;
      seed      = 8'h00;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b1;
      model_reset();

      #12;
      chk_eq("rst_valid", 32'(out_valid), 32'd0);
      chk_eq("rst_masked", 32'(out_masked), 32'd0);
      chk_eq("rst_mask", 32'(out_mask), 32'd0);
      chk_eq("rst_count", 32'(out_count), 32'd0);
      chk_eq("rst_ready", 32'(in_ready), 32'd1);
      chk_eq("rst_lfsr", 32'(dut.lfsr_value), 32'h01);
      @(negedge clk);
      rst_n = 1'b1;

      // first acceptance of 4'hA after reset
      in_valid = 1'b1;
      in_data  = 4'hA;
      step();
      chk_eq("a_masked", 32'(out_masked), MASK_ON ? 32'h173 : 32'h036);
      chk_eq("a_mask", 32'(out_mask), MASK_ON ? 32'h145 : 32'h000);
      chk_eq("a_lfsr", 32'(dut.lfsr_value), 32'hB8);
      step();
      chk_eq("a2_mask", 32'(out_mask), MASK_ON ? 32'(ref_expand(8)) : 32'h000);
      chk_eq("a2_lfsr", 32'(dut.lfsr_value), 32'h5C);

      // back-to-back stream
      stream     = '{4'hF, 4'h5, 4'h3};
      stream_exp = '{9'h01B, 9'h02D, 9'h0C3};
      for (int i = 0; i < 3; i++) begin
         in_data = stream[i];
         step();
         chk_eq("stream_valid", 32'(out_valid), 32'd1);
         chk_eq("stream_comb", 32'(out_masked ^ out_mask), 32'(stream_exp[i]));
      end

      // zero seed, then seed load concurrent with acceptance
      in_valid  = 1'b0;
      seed_load = 1'b1;
      seed      = 8'h00;
      step();
      chk_eq("seed_zero", 32'(dut.lfsr_value), 32'h01);
      in_valid = 1'b1;
      in_data  = 4'h6;
      seed     = 8'h5A;
      step();
      chk_eq("seed_acc_lfsr", 32'(dut.lfsr_value), 32'h5A);
      chk_eq("seed_acc_mask", 32'(out_mask), MASK_ON ? 32'(ref_expand(1)) : 32'h000);
      seed_load = 1'b0;

      // drain, then hold off the consumer for five cycles
      in_valid = 1'b0;
      step();
      in_valid = 1'b1;
      in_data  = 4'h9;
      out_ready = 1'b0;
      step();
      held_masked = out_masked;
      held_mask   = out_mask;
      held_count  = out_count;
      for (int i = 0; i < 5; i++) begin
         in_data = 4'(i + 2);
         step();
         chk_eq("stall_ready", 32'(in_ready), 32'd0);
         chk_eq("stall_masked", 32'(out_masked), 32'(held_masked));
         chk_eq("stall_mask", 32'(out_mask), 32'(held_mask));
         chk_eq("stall_count", 32'(out_count), 32'(held_count));
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 3) != 0);
         in_data   = 4'($urandom);
         seed_load = 1'($urandom_range(0, 15) == 0);
         seed      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         step();
      end
      seed_load = 1'b0;

      // reset while a pair is held
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_data   = 4'hC;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      chk_eq("mid_rst_count", 32'(out_count), 32'd0);
      chk_eq("mid_rst_masked", 32'(out_masked), 32'd0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_eq("post_rst_lfsr", 32'(dut.lfsr_value), 32'h01);
      chk_eq("post_rst_valid", 32'(out_valid), 32'd0);

      // 256 acceptances from zero wrap the counter back to zero
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 4'($urandom);
         step();
      end
      chk_eq("wrap", 32'(out_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
